// File: rtl/int_seq_ctrl_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encoding, default
// handler vector and the vector slot stride used when INTC_VECTORED_EN is set.
package int_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_ISR     = 2'd2,
        ST_RESTORE = 2'd3
    } int_state_t;

    localparam logic [31:0] VEC_BASE_DEF = 32'h0000_1c00;

    // Each vectored handler slot is 16 bytes.
    localparam logic [31:0] VEC_STRIDE   = 32'd16;

endpackage

// File: rtl/int_seq_ctrl_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder (bit 0 highest priority).
// Returns a valid flag and the index of the winning request.
module irq_prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = 5
) (
    input  logic [W-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_seq_ctrl.sv
// int_seq_ctrl: interrupt sequencer producing INT_detected / INT_restore
// pulses for the stage registers and the NPC redirect for entry and mret.
// Optional macro INTC_VECTORED_EN: handler target is VEC_BASE + 16*index
// instead of a single shared VEC_BASE entry.
module int_seq_ctrl
    import int_seq_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ  = 8,
    parameter logic [31:0] VEC_BASE = VEC_BASE_DEF,
    parameter int          CAUSE_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               glb_ie,
    input  logic [31:0]        MEM_PC,
    input  logic               EX_mret,
    input  logic               pipe_stall,
    output logic               INT_detected,
    output logic               INT_restore,
    output logic               int_pc_sel,
    output logic [31:0]        int_target_pc,
    output logic [31:0]        epc,
    output logic [CAUSE_W-1:0] cause,
    output logic               in_isr,
    output logic [NUM_IRQ-1:0] irq_ack
);

    generate
        if (NUM_IRQ < 1 || NUM_IRQ > 32 || NUM_IRQ > (1 << CAUSE_W)) begin : g_bad_cfg
            $error("int_seq_ctrl: NUM_IRQ must be 1..32 and fit in CAUSE_W bits");
        end
    endgenerate

    int_state_t         r_state;
    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_pending;
    logic [CAUSE_W-1:0] r_sel_idx;
    logic               r_mret_q;
    logic               r_int_det;
    logic               r_int_rst;
    logic               r_pc_sel;
    logic [31:0]        r_target;
    logic [31:0]        r_epc;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_in_isr;
    logic [NUM_IRQ-1:0] r_ack;

    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_clr;
    logic               w_valid;
    logic [CAUSE_W-1:0] w_idx;
    logic [31:0]        w_vec;

    assign w_eligible = r_pending & irq_en;
    assign w_clr      = (r_state == ST_ENTER) ? (NUM_IRQ'(1) << r_sel_idx) : '0;

`ifdef INTC_VECTORED_EN
    assign w_vec = VEC_BASE + (32'(w_idx) * VEC_STRIDE);
`else
    assign w_vec = VEC_BASE;
`endif

    irq_prio_enc #(
        .W     (NUM_IRQ),
        .IDX_W (CAUSE_W)
    ) u_prio (
        .i_req   (w_eligible),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // Edge-detect requests into pending; a new edge beats the ENTER clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_irq_prev <= irq_in;
            r_pending  <= (r_pending & ~w_clr) | (irq_in & ~r_irq_prev);
        end
    end

    // Sequencer FSM with registered pulse / redirect outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sel_idx <= '0;
            r_mret_q  <= 1'b0;
            r_int_det <= 1'b0;
            r_int_rst <= 1'b0;
            r_pc_sel  <= 1'b0;
            r_target  <= '0;
            r_epc     <= '0;
            r_cause   <= '0;
            r_in_isr  <= 1'b0;
            r_ack     <= '0;
        end else begin
            r_int_det <= 1'b0;
            r_int_rst <= 1'b0;
            r_pc_sel  <= 1'b0;
            r_target  <= '0;
            r_ack     <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (glb_ie && w_valid && !pipe_stall) begin
                        r_state   <= ST_ENTER;
                        r_sel_idx <= w_idx;
                        r_int_det <= 1'b1;
                        r_pc_sel  <= 1'b1;
                        r_target  <= w_vec;
                        r_ack     <= NUM_IRQ'(1) << w_idx;
                    end
                end
                ST_ENTER: begin
                    r_epc    <= MEM_PC;
                    r_cause  <= r_sel_idx;
                    r_in_isr <= 1'b1;
                    r_state  <= ST_ISR;
                end
                ST_ISR: begin
                    if ((EX_mret || r_mret_q) && !pipe_stall) begin
                        r_state   <= ST_RESTORE;
                        r_int_rst <= 1'b1;
                        r_pc_sel  <= 1'b1;
                        r_target  <= r_epc;
                    end else if (EX_mret) begin
                        r_mret_q  <= 1'b1;
                    end
                end
                ST_RESTORE: begin
                    r_mret_q <= 1'b0;
                    r_in_isr <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign INT_detected  = r_int_det;
    assign INT_restore   = r_int_rst;
    assign int_pc_sel    = r_pc_sel;
    assign int_target_pc = r_target;
    assign epc           = r_epc;
    assign cause         = r_cause;
    assign in_isr        = r_in_isr;
    assign irq_ack       = r_ack;

endmodule

// File: doc/int_seq_ctrl.md
Name: int_seq_ctrl

Overview:
- Interrupt sequencer that generates the INT_detected / INT_restore pulses consumed by the pipeline stage registers.
- On interrupt entry it pulses INT_detected, captures the EPC and cause, and redirects fetch to the handler vector.
- On handler return (mret) it pulses INT_restore and redirects fetch back to the EPC.
- Sits beside the hazard unit; its outputs fan out to every stage register and to the NPC mux.

Parameters:
- NUM_IRQ, 8, number of external interrupt sources (1..32).
- VEC_BASE, 32'h0000_1c00, handler entry address.
- CAUSE_W, 5, width of the cause index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  raw interrupt request lines, already synchronous to clk.
- irq_en  in  NUM_IRQ  per-source enable mask.
- glb_ie  in  1  global interrupt enable.
- MEM_PC  in  32  PC of the instruction in MEM; saved as EPC.
- EX_mret  in  1  return-from-interrupt decoded in EX.
- pipe_stall  in  1  pipeline stalled; defers entry and return.
- INT_detected  out  1  one-cycle pulse at entry; stage registers save state.
- INT_restore  out  1  one-cycle pulse at return; stage registers reload state.
- int_pc_sel  out  1  high selects int_target_pc as next PC.
- int_target_pc  out  32  handler vector, or EPC on return.
- epc  out  32  saved return PC.
- cause  out  CAUSE_W  index of the serviced source.
- in_isr  out  1  handler currently active.
- irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of the taken source.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; pending=0; irq_prev=0; epc=0; cause=0.
  - All outputs are 0 during and after reset.
  - Reset asserted mid-ISR abandons the handler; no INT_restore is issued.
- Pending capture:
  - irq_prev registers irq_in.
  - pending[i] is set on a rising edge of irq_in[i] (irq_in & ~irq_prev).
  - pending[i] is cleared in the ENTER cycle for the taken source only.
  - If a set and a clear of the same bit coincide, the set wins.
  - Masked sources still latch into pending.
- Selection: eligible = pending & irq_en; the lowest set index wins (fixed priority, bit 0 highest).
- FSM, registered state:
  - IDLE: if glb_ie && |eligible && !pipe_stall, go to ENTER and register the winning index as sel_idx.
    - Otherwise stay in IDLE.
    - EX_mret in IDLE is ignored.
  - ENTER (exactly 1 cycle):
    - INT_detected=1, int_pc_sel=1, int_target_pc=VEC_BASE.
    - irq_ack[sel_idx]=1.
    - epc<=MEM_PC, cause<=sel_idx, pending[sel_idx]<=0.
    - Next state ISR.
  - ISR:
    - in_isr=1; no nesting; new edges only latch into pending.
    - EX_mret && !pipe_stall goes to RESTORE.
    - EX_mret while pipe_stall is held is not lost; it is latched into mret_q and acted on when the stall drops.
  - RESTORE (exactly 1 cycle):
    - INT_restore=1, int_pc_sel=1, int_target_pc=epc, in_isr=1.
    - Next state IDLE; mret_q cleared.
- Latency:
  - Edge on irq_in at cycle N: pending is visible in N+1, ENTER outputs appear in N+2 (when enabled and not stalled).
  - mret seen at cycle M gives RESTORE outputs at M+1.
  - Back-to-back service: a source pending at RESTORE may enter no earlier than 1 cycle after returning to IDLE; at least one IDLE cycle is guaranteed.
- INT_detected and INT_restore are never high in the same cycle.
- epc and cause hold their values until the next ENTER.
- Width rules:
  - cause is zero-extended from the index.
  - NUM_IRQ > 2^CAUSE_W is illegal; guard it with an elaboration check.

Optional Feature:
- Macro INTC_VECTORED_EN.
- Defined: ENTER target = VEC_BASE + (sel_idx << 4), i.e. 16-byte vector slots.
- Undefined: every source enters at VEC_BASE; software reads cause.
- All other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, ENTER=2'd1, ISR=2'd2, RESTORE=2'd3.
  - VEC_BASE default.
  - The 16-byte vector stride constant.
- One natural sub-module: irq_prio_enc. It is a parameterized lowest-index priority encoder returning a valid flag and an index; it is reusable by the hazard unit.

Test Plan:
1. Reset release, then irq_in[3] rises with irq_en=8'hFF, glb_ie=1, MEM_PC=32'h0000_0040 -> two cycles later INT_detected=1, irq_ack=8'h08, int_target_pc=32'h1c00, epc=32'h40, cause=3; in_isr=1 from the next cycle.
2. irq_in[5] and irq_in[1] rise together -> source 1 is serviced first (cause=1). After mret and RESTORE (INT_restore=1, int_target_pc=epc) plus one IDLE cycle, source 5 enters.
3. irq_in[2] rises with irq_en[2]=0 -> no entry; setting irq_en[2]=1 later triggers entry, cause=2.
4. pipe_stall=1 held for 4 cycles with an eligible source -> no INT_detected until the stall drops; likewise EX_mret under stall is deferred and RESTORE follows the stall release.
5. reset driven low mid-ISR -> all outputs 0 immediately; no INT_restore is issued.
6. With INTC_VECTORED_EN defined, source 6 -> int_target_pc=32'h1c60; without the macro -> 32'h1c00.
